win_detector: RTL and testbench

- Downstream of the column selector stage. Consumes the 16-bit occupancy board and the 16-bit player-ownership board.
- On each `start` it snapshots both boards, then scans the 10 winning lines of the 4x4 grid, one line per clock.
- Reports winner, draw, or no result to the game FSM, which uses the result to move to END_GAME or to the next turn.
- Cell index = 4*row + col; row 0 is the bottom row.

---
 rtl/win_detector_pkg.sv | 51 +++++
 rtl/win_detector_if.sv | 37 +++
 rtl/win_detector_line_checker.sv | 26 ++
 rtl/win_detector.sv | 171 +++++++++++++++++
 tb/tb_win_detector.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/win_detector_pkg.sv
// Shared board constants, line lookup and FSM encoding for the win detector.
// Cells are numbered 4*row + col, with row 0 at the bottom.
package win_detector_pkg;

  localparam int N_ROWS  = 4;
  localparam int N_COLS  = 4;
  localparam int N_CELLS = N_ROWS * N_COLS;
  localparam int N_LINES = 10;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef logic [3:0] cell_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Packed {c3,c2,c1,c0}; c0 is the cell whose owner names the winner.
  function automatic logic [15:0] line_cells(input logic [3:0] idx);
    logic [15:0] r;
    case (idx)
      4'd0:    r = 16'h3210;
      4'd1:    r = 16'h7654;
      4'd2:    r = 16'hBA98;
      4'd3:    r = 16'hFEDC;
      4'd4:    r = 16'hC840;
      4'd5:    r = 16'hD951;
      4'd6:    r = 16'hEA62;
      4'd7:    r = 16'hFB73;
      4'd8:    r = 16'hFA50;
      4'd9:    r = 16'hC963;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  function automatic logic [N_CELLS-1:0] line_mask(input logic [3:0] idx);
    logic [15:0]        cells;
    logic [N_CELLS-1:0] m;
    cells = line_cells(idx);
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[cells[4*i +: 4]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/win_detector_if.sv
// Request/result bundle between the game FSM and the win detector.
// WIN_DETECTOR_MASK_EN adds the win_mask highlight bus.
interface win_detector_if #(
  parameter int LINE_W = 4
);
  logic              clear;
  logic              start;
  logic [15:0]       gameboard;
  logic [15:0]       players_cells;
  logic              busy;
  logic              done;
  logic              win;
  logic              winner;
  logic              draw;
  logic [LINE_W-1:0] win_line;
`ifdef WIN_DETECTOR_MASK_EN
  logic [15:0]       win_mask;

  modport master (
    output clear, start, gameboard, players_cells,
    input  busy, done, win, winner, draw, win_line, win_mask
  );
  modport slave (
    input  clear, start, gameboard, players_cells,
    output busy, done, win, winner, draw, win_line, win_mask
  );
`else
  modport master (
    output clear, start, gameboard, players_cells,
    input  busy, done, win, winner, draw, win_line
  );
  modport slave (
    input  clear, start, gameboard, players_cells,
    output busy, done, win, winner, draw, win_line
  );
`endif
endinterface

// File: rtl/win_detector_line_checker.sv
// Combinational test of one 4-cell line against the board snapshots.
// Time-shared by the scan; empty cells never form a line.
module win_detector_line_checker
  import win_detector_pkg::*;
(
  input  cell_t              c0,
  input  cell_t              c1,
  input  cell_t              c2,
  input  cell_t              c3,
  input  logic [N_CELLS-1:0] board,
  input  logic [N_CELLS-1:0] owns,
  output logic               hit,
  output logic               owner
);

  logic occ;
  logic same;

  assign occ   = board[c0] & board[c1] & board[c2] & board[c3];
  assign same  = (owns[c0] == owns[c1]) &&
                 (owns[c0] == owns[c2]) &&
                 (owns[c0] == owns[c3]);
  assign hit   = occ && same;
  assign owner = owns[c0];

endmodule

// File: rtl/win_detector.sv
// Snapshots the boards on start and scans the 10 lines one per clock.
// WIN_DETECTOR_MASK_EN adds the registered win_mask output.
module win_detector
  import win_detector_pkg::*;
#(
  parameter int EARLY_EXIT = 1,
  parameter int LINE_W     = 4
) (
  input logic           clk,
  input logic           rst_n,
  win_detector_if.slave bus
);

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [N_CELLS-1:0] gb_q, gb_d;
  logic [N_CELLS-1:0] pc_q, pc_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               win_q, win_d;
  logic               winner_q, winner_d;
  logic               draw_q, draw_d;
`ifdef WIN_DETECTOR_MASK_EN
  logic [N_CELLS-1:0] mask_q, mask_d;
`endif

  logic [15:0] cells;
  logic        hit;
  logic        owner;

  assign cells = line_cells(4'(cnt_q));

  win_detector_line_checker u_chk (
    .c0    (cells[3:0]),
    .c1    (cells[7:4]),
    .c2    (cells[11:8]),
    .c3    (cells[15:12]),
    .board (gb_q),
    .owns  (pc_q),
    .hit   (hit),
    .owner (owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      gb_q     <= '0;
      pc_q     <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      winner_q <= P1;
      draw_q   <= 1'b0;
`ifdef WIN_DETECTOR_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      gb_q     <= gb_d;
      pc_q     <= pc_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      win_q    <= win_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
`ifdef WIN_DETECTOR_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    gb_d     = gb_q;
    pc_d     = pc_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    win_d    = win_q;
    winner_d = winner_q;
    draw_d   = draw_q;
`ifdef WIN_DETECTOR_MASK_EN
    mask_d   = mask_q;
`endif
    if (bus.clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      line_d   = '0;
      last_d   = 1'b0;
      busy_d   = 1'b0;
      win_d    = 1'b0;
      winner_d = P1;
      draw_d   = 1'b0;
`ifdef WIN_DETECTOR_MASK_EN
      mask_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            gb_d     = bus.gameboard;
            pc_d     = bus.players_cells;
            cnt_d    = '0;
            line_d   = '0;
            last_d   = 1'b0;
            busy_d   = 1'b1;
            win_d    = 1'b0;
            winner_d = P1;
            draw_d   = 1'b0;
`ifdef WIN_DETECTOR_MASK_EN
            mask_d   = '0;
`endif
            state_d  = SCAN;
          end
        end
        SCAN: begin
          // Trailing cycle after line 9 settles draw and fixes latency.
          if (last_q) begin
            draw_d  = !win_q && (gb_q == '1);
            last_d  = 1'b0;
            state_d = REPORT;
          end else begin
            if (hit && (EARLY_EXIT != 0 || !win_q)) begin
              win_d    = 1'b1;
              winner_d = owner;
              line_d   = cnt_q;
`ifdef WIN_DETECTOR_MASK_EN
              mask_d   = line_mask(4'(cnt_q));
`endif
            end
            if (hit && EARLY_EXIT != 0) begin
              state_d = REPORT;
            end else if (cnt_q == LINE_W'(N_LINES - 1)) begin
              last_d = 1'b1;
            end else begin
              cnt_d = cnt_q + LINE_W'(1);
            end
          end
        end
        REPORT: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.win      = win_q;
  assign bus.winner   = winner_q;
  assign bus.draw     = draw_q;
  assign bus.win_line = line_q;
`ifdef WIN_DETECTOR_MASK_EN
  assign bus.win_mask = mask_q;
`endif

endmodule

// File: tb/tb_win_detector.sv
// Directed bench for win_detector with an independent line-scan model.
// Define WIN_DETECTOR_MASK_EN to also check win_mask.
module tb_win_detector;

  localparam int EE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  win_detector_if bus_if ();

  win_detector #(.EARLY_EXIT(EE), .LINE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  bit   pending = 1'b0;
  int   start_at = 0;
  int   done_at = 0;
  logic e_win = 1'b0;
  logic e_winner = 1'b0;
  logic e_draw = 1'b0;
  logic [3:0]  e_line = '0;
  logic [15:0] e_mask = '0;
  int   e_lat = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lines built from grid geometry: rows, columns, then the two diagonals.
  task automatic model(input logic [15:0] gb, input logic [15:0] pc);
    int c[4];
    bit occ;
    bit same;
    bit found;
    found    = 1'b0;
    e_win    = 1'b0;
    e_winner = 1'b0;
    e_line   = '0;
    e_mask   = '0;
    for (int l = 0; l < 10; l++) begin
      for (int i = 0; i < 4; i++) begin
        if (l < 4)       c[i] = 4*l + i;
        else if (l < 8)  c[i] = (l - 4) + 4*i;
        else if (l == 8) c[i] = 5*i;
        else             c[i] = 3 + 3*i;
      end
      occ  = 1'b1;
      same = 1'b1;
      for (int i = 0; i < 4; i++) begin
        occ  = occ & gb[c[i]];
        same = same & (pc[c[i]] == pc[c[0]]);
      end
      if (occ && same && !found) begin
        found    = 1'b1;
        e_win    = 1'b1;
        e_winner = pc[c[0]];
        e_line   = 4'(l);
        for (int i = 0; i < 4; i++) e_mask[c[i]] = 1'b1;
      end
    end
    e_draw = !found && (gb == 16'hFFFF);
    e_lat  = (found && EE != 0) ? int'(e_line) + 2 : 12;
  endtask

  bit exp_busy;
  bit exp_done;
  always @(negedge clk) begin
    exp_done = pending && (cyc == done_at);
    exp_busy = pending && (cyc >= start_at) && (cyc < done_at);
    chk("done", bus_if.done, exp_done);
    chk("busy", bus_if.busy, exp_busy);
    if (!pending || cyc >= done_at) begin
      chk("win", bus_if.win, e_win);
      chk("draw", bus_if.draw, e_draw);
      if (e_win) begin
        chk("winner", bus_if.winner, e_winner);
        chk("win_line", bus_if.win_line, e_line);
`ifdef WIN_DETECTOR_MASK_EN
        chk("win_mask", bus_if.win_mask, e_mask);
      end else begin
        chk("win_mask_zero", bus_if.win_mask, 16'h0000);
`endif
      end
    end
  end

  task automatic zero_exp();
    pending  = 1'b0;
    e_win    = 1'b0;
    e_winner = 1'b0;
    e_draw   = 1'b0;
    e_line   = '0;
    e_mask   = '0;
  endtask

  task automatic launch(input logic [15:0] gb, input logic [15:0] pc);
    @(posedge clk); #1;
    model(gb, pc);
    bus_if.start         = 1'b1;
    bus_if.gameboard     = gb;
    bus_if.players_cells = pc;
    start_at = cyc + 1;
    done_at  = start_at + e_lat;
    pending  = 1'b1;
    @(posedge clk); #1;
    bus_if.start         = 1'b0;
    bus_if.gameboard     = ~gb;
    bus_if.players_cells = ~pc;
  endtask

  task automatic run(input logic [15:0] gb, input logic [15:0] pc,
                     input int lat, input bit w, input bit wn,
                     input int ln, input bit dr, input bit repulse);
    launch(gb, pc);
    chk("model_lat", e_lat, lat);
    chk("model_win", e_win, w);
    chk("model_draw", e_draw, dr);
    if (w) begin
      chk("model_winner", e_winner, wn);
      chk("model_line", e_line, ln);
    end
    if (repulse) begin
      @(posedge clk); #1;
      bus_if.start         = 1'b1;
      bus_if.gameboard     = 16'h000F;
      bus_if.players_cells = 16'h0000;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
    end
    while (cyc <= done_at + 1) begin
      @(posedge clk); #1;
    end
    pending = 1'b0;
  endtask

  task automatic abort_start(input logic [15:0] gb, input logic [15:0] pc);
    launch(gb, pc);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus_if.clear         = 1'b0;
    bus_if.start         = 1'b0;
    bus_if.gameboard     = '0;
    bus_if.players_cells = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(16'h000F, 16'h0000, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run(16'h1248, 16'h1248, 11, 1'b1, 1'b1, 9, 1'b0, 1'b0);
`ifdef WIN_DETECTOR_MASK_EN
    chk("model_mask", e_mask, 16'h1248);
`endif
    run(16'h0000, 16'h0000, 12, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run(16'hFFFF, 16'h3CC3, 12, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run(16'h2222, 16'h2222, 7, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    run(16'h00FF, 16'h00F0, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run(16'h8421, 16'h0000, 10, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    run(16'hF000, 16'hF000, 5, 1'b1, 1'b1, 3, 1'b0, 1'b1);

    // Clear while idle drops the held results.
    @(posedge clk); #1;
    bus_if.clear = 1'b1;
    @(posedge clk); #1;
    bus_if.clear = 1'b0;
    zero_exp();
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-scan.
    abort_start(16'h0000, 16'h0000);
    zero_exp();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_done", bus_if.done, 1'b0);
    chk("rst_win", bus_if.win, 1'b0);
    chk("rst_line", bus_if.win_line, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    run(16'h000F, 16'h0000, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Clear mid-scan, asserted together with a start request.
    abort_start(16'hFFFF, 16'h3CC3);
    bus_if.clear = 1'b1;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.clear = 1'b0;
    bus_if.start = 1'b0;
    zero_exp();
    chk("clr_busy", bus_if.busy, 1'b0);
    repeat (14) @(posedge clk);
    run(16'hF000, 16'hF000, 5, 1'b1, 1'b1, 3, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
